game_event_sequencer: RTL

Game-control stage directly upstream of the VGA picture selector. It converts coin, abort and ball-sensor pulses into the io_game_start / io_game_abort / io_high_score / io_low_score / io_highest_score_ever events that drive picture selection. It also runs the game countdown, accumulates the score and keeps the best-ever score. End-of-game events are held as levels long enough to outlast the display's ~3 s feedback pictures, so the display cannot miss them.

---
 rtl/game_event_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/game_event_sequencer.sv
// Game-control stage ahead of the VGA picture selector: turns coin/abort/ball pulses into
// display events, runs the countdown, keeps score and the best-ever score.
module game_event_sequencer #(
  parameter int CLK_PER_SEC     = 100_000_000,
  parameter int GAME_SECS       = 60,
  parameter int POINTS_PER_SHOT = 2,
  parameter int END_HOLD        = 800_000_000
) (
  input  logic       clk,
  input  logic       onepulsed_rst,
  input  logic       coin_pulse,
  input  logic       abort_pulse,
  input  logic       hoop_pulse,
  input  logic       miss_pulse,
  output logic       io_game_start,
  output logic       io_game_abort,
  output logic       io_high_score,
  output logic       io_low_score,
  output logic       io_highest_score_ever,
  output logic [7:0] score,
  output logic [7:0] best_score,
  output logic [6:0] secs_left,
  output logic       playing
);

  // state   | meaning
  // IDLE    | waiting for a coin; last score and best score on display
  // PLAYING | countdown running, hoop/miss/abort pulses accepted
  // ENDING  | end-of-game level (abort or record) held for END_HOLD cycles
  typedef enum logic [1:0] {IDLE, PLAYING, ENDING} state_t;

  localparam logic [29:0] PRESCALE_LAST = 30'(CLK_PER_SEC - 1);
  localparam logic [29:0] HOLD_LAST     = 30'(END_HOLD - 1);
  localparam logic [6:0]  SECS_INIT     = 7'(GAME_SECS);
  localparam logic [8:0]  SHOT          = 9'(POINTS_PER_SHOT);

  state_t      state;
  logic [29:0] prescaler;
  logic [29:0] hold_cnt;

  logic       tick;
  logic       timeout;
  logic [8:0] score_sum;
  logic [7:0] score_hit;
  logic [7:0] score_next;

  assign tick       = (prescaler == PRESCALE_LAST);
  assign timeout    = tick && (secs_left == 7'd1);
  assign score_sum  = {1'b0, score} + SHOT;
  assign score_hit  = score_sum[8] ? 8'hFF : score_sum[7:0];
  // A hoop landing on the final tick still counts toward the record decision.
  assign score_next = hoop_pulse ? score_hit : score;

  always_ff @(posedge clk or posedge onepulsed_rst) begin
    if (onepulsed_rst) begin
      state                 <= IDLE;
      prescaler             <= '0;
      hold_cnt              <= '0;
      io_game_start         <= 1'b0;
      io_game_abort         <= 1'b0;
      io_high_score         <= 1'b0;
      io_low_score          <= 1'b0;
      io_highest_score_ever <= 1'b0;
      score                 <= '0;
      best_score            <= '0;
      secs_left             <= '0;
      playing               <= 1'b0;
    end else begin
      io_game_start <= 1'b0;
      io_high_score <= 1'b0;
      io_low_score  <= 1'b0;

      case (state)
        IDLE: begin
          if (coin_pulse) begin
            state         <= PLAYING;
            playing       <= 1'b1;
            score         <= '0;
            secs_left     <= SECS_INIT;
            prescaler     <= '0;
            io_game_start <= 1'b1;
          end
        end

        PLAYING: begin
          if (abort_pulse) begin
            state         <= ENDING;
            playing       <= 1'b0;
            hold_cnt      <= '0;
            io_game_abort <= 1'b1;
          end else begin
            if (hoop_pulse) begin
              score         <= score_hit;
              io_high_score <= 1'b1;
            end else if (miss_pulse) begin
              io_low_score <= 1'b1;
            end

            if (tick) begin
              prescaler <= '0;
              secs_left <= secs_left - 7'd1;
            end else begin
              prescaler <= prescaler + 30'd1;
            end

            if (timeout) begin
              state    <= ENDING;
              playing  <= 1'b0;
              hold_cnt <= '0;
              // A tie with the best score is not a record.
              if (score_next > best_score) begin
                best_score            <= score_next;
                io_highest_score_ever <= 1'b1;
              end else begin
                io_game_abort <= 1'b1;
              end
            end
          end
        end

        ENDING: begin
          if (hold_cnt == HOLD_LAST) begin
            state                 <= IDLE;
            io_game_abort         <= 1'b0;
            io_highest_score_ever <= 1'b0;
          end else begin
            hold_cnt <= (hold_cnt == '1) ? hold_cnt : hold_cnt + 30'd1;
          end
        end

        default: begin
          state                 <= IDLE;
          playing               <= 1'b0;
          io_game_abort         <= 1'b0;
          io_highest_score_ever <= 1'b0;
        end
      endcase
    end
  end

endmodule
